// File: rtl/mapache64.sv
// Shared mapache64 VRAM bus types and text-table constants used by VRAM initiators.
package mapache64;
  typedef logic [11:0] vram_address_t;
  typedef logic [7:0]  data_t;

  localparam vram_address_t TXBL_BASE = 12'h900;
  localparam int            TXT_COLS  = 32;
  localparam int            TXT_ROWS  = 30;

  localparam data_t CHR_LF = 8'h0A;
  localparam data_t CHR_CR = 8'h0D;
  localparam data_t CHR_BS = 8'h08;
  localparam data_t CHR_FF = 8'h0C;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} text_writer_state_t;
endpackage

// File: rtl/text_writer_pkg.sv
// Text console helpers: cursor operation codes, clear-range limits and TXBL address math.
package text_writer_pkg;
  import mapache64::*;

  typedef enum logic [2:0] {
    CUR_NONE, CUR_ADVANCE, CUR_NEWLINE, CUR_RETURN, CUR_BACKSPACE, CUR_HOME
  } cursor_op_t;

  localparam int         TXBL_ENTRIES = TXT_COLS * TXT_ROWS;
  localparam logic [9:0] CLR_LAST     = 10'(TXBL_ENTRIES - 1);

  // The 10-bit offset is zero-extended so no carry can leave the text table.
  function automatic vram_address_t txbl_addr(input logic [9:0] off);
    return TXBL_BASE + {2'b00, off};
  endfunction

  function automatic logic is_printable(input data_t c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction
endpackage

// File: rtl/text_writer_if.sv
// Byte-stream handshake plus VRAM write-initiator signals of the text console.
interface text_writer_if;
  logic                     char_valid_i;
  logic                     char_ready_o;
  logic [7:0]               char_i;
  logic                     color_i;
  logic                     gnt_i;
  mapache64::vram_address_t vram_address_o;
  mapache64::data_t         data_o;
  logic                     wen_o;
  logic                     SELECT_txbl_o;

  modport master (
    output char_valid_i, char_i, color_i, gnt_i,
    input  char_ready_o, vram_address_o, data_o, wen_o, SELECT_txbl_o
  );

  modport slave (
    input  char_valid_i, char_i, color_i, gnt_i,
    output char_ready_o, vram_address_o, data_o, wen_o, SELECT_txbl_o
  );
endinterface

// File: rtl/text_cursor.sv
// Row/column cursor of the text grid; rows wrap to 0 after the last row (no scrolling).
module text_cursor
  import text_writer_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 30
) (
  input  logic       cpu_clk,
  input  logic       rst,
  input  cursor_op_t op_i,
  output logic [4:0] row_o,
  output logic [4:0] col_o
);
  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  logic [4:0] row_q, row_d, col_q, col_d, row_inc;

  always_comb row_inc = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    unique case (op_i)
      CUR_ADVANCE: begin
        if (col_q == COL_LAST) begin
          col_d = 5'd0;
          row_d = row_inc;
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      CUR_NEWLINE: begin
        col_d = 5'd0;
        row_d = row_inc;
      end
      CUR_RETURN: col_d = 5'd0;
      CUR_BACKSPACE: begin
        // Backspace at the top-left corner is a no-op rather than a wrap.
        if (col_q != 5'd0) begin
          col_d = col_q - 5'd1;
        end else if (row_q != 5'd0) begin
          col_d = COL_LAST;
          row_d = row_q - 5'd1;
        end
      end
      CUR_HOME: begin
        row_d = 5'd0;
        col_d = 5'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      row_q <= 5'd0;
      col_q <= 5'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
endmodule

// File: rtl/text_writer.sv
// Text console VRAM initiator: turns a byte stream into TXBL writes and handles control codes.
module text_writer
  import mapache64::*;
  import text_writer_pkg::*;
#(
  parameter int COLS = TXT_COLS,
  parameter int ROWS = TXT_ROWS
) (
  input  logic                cpu_clk,
  input  logic                rst,
  text_writer_if.slave        bus,
  output logic [4:0]          cursor_row_o,
  output logic [4:0]          cursor_col_o,
  output logic                busy_o
);
  text_writer_state_t state_q, state_d;
  vram_address_t      addr_q, addr_d;
  data_t              data_q, data_d;
  logic [9:0]         clr_q, clr_d;
  cursor_op_t         cur_op;
  logic               ready;
  logic               accept;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .op_i    (cur_op),
    .row_o   (cursor_row_o),
    .col_o   (cursor_col_o)
  );

  // Ready depends only on state and reset, never on valid or grant.
  assign ready  = (state_q == IDLE) && !rst;
  assign accept = bus.char_valid_i && ready;

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 10'd0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_ff @(posedge cpu_clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    clr_d   = clr_q;
    cur_op  = CUR_NONE;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_printable(bus.char_i)) begin
            state_d = WRITE;
            addr_d  = txbl_addr({cursor_row_o, cursor_col_o});
            data_d  = {bus.color_i, bus.char_i[6:0]};
          end else begin
            case (bus.char_i)
              CHR_LF: cur_op = CUR_NEWLINE;
              CHR_CR: cur_op = CUR_RETURN;
              CHR_BS: cur_op = CUR_BACKSPACE;
              CHR_FF: begin
                state_d = CLEAR;
                clr_d   = 10'd0;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        if (bus.gnt_i) begin
          state_d = IDLE;
          cur_op  = CUR_ADVANCE;
        end
      end
      CLEAR: begin
        if (bus.gnt_i) begin
          if (clr_q == CLR_LAST) begin
            state_d = IDLE;
            cur_op  = CUR_HOME;
          end else begin
            clr_d = clr_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode from state and held registers, so they stay stable across a grant cycle.
  always_comb begin
    bus.wen_o          = 1'b0;
    bus.vram_address_o = '0;
    bus.data_o         = '0;
    busy_o             = 1'b0;
    case (state_q)
      WRITE: begin
        bus.wen_o          = 1'b1;
        bus.vram_address_o = addr_q;
        bus.data_o         = data_q;
        busy_o             = 1'b1;
      end
      CLEAR: begin
        bus.wen_o          = 1'b1;
        bus.vram_address_o = txbl_addr(clr_q);
        bus.data_o         = 8'h00;
        busy_o             = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.SELECT_txbl_o = bus.wen_o;
  assign bus.char_ready_o  = ready;
endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: printable writes, control codes, wraps, clear and reset abort.
module tb_text_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] row, col;
  logic       busy;

  text_writer_if bus ();

  text_writer #(.COLS(32), .ROWS(30)) dut (
    .cpu_clk      (clk),
    .rst          (rst),
    .bus          (bus),
    .cursor_row_o (row),
    .cursor_col_o (col),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:959];
  int         wr_cnt = 0;

  // Text-layer model: a write lands on the negedge of a granted cycle.
  always @(negedge clk) begin
    int idx;
    if (rst === 1'b0 && bus.wen_o === 1'b1 && bus.gnt_i === 1'b1) begin
      idx = int'(bus.vram_address_o) - 'h900;
      if (idx >= 0 && idx < 960) mem[idx] = bus.data_o;
      wr_cnt++;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic c);
    int n;
    bus.char_i       = b;
    bus.color_i      = c;
    bus.char_valid_i = 1'b1;
    tick();
    bus.char_valid_i = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk("send_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt0, k, bad;
    bit  done;
    bus.char_i       = 8'h00;
    bus.color_i      = 1'b0;
    bus.char_valid_i = 1'b0;
    bus.gnt_i        = 1'b0;
    rst              = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wen",   32'(bus.wen_o), 32'd0);
    chk("rst_sel",   32'(bus.SELECT_txbl_o), 32'd0);
    chk("rst_addr",  32'(bus.vram_address_o), 32'd0);
    chk("rst_data",  32'(bus.data_o), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.char_ready_o), 32'd0);
    chk("rst_row",   32'(row), 32'd0);
    chk("rst_col",   32'(col), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.char_ready_o), 32'd1);

    // 'A' with colour bit, grant held high
    bus.gnt_i = 1'b1;
    bus.char_i = 8'h41; bus.color_i = 1'b1; bus.char_valid_i = 1'b1;
    tick();
    bus.char_valid_i = 1'b0;
    @(negedge clk);
    chk("a_wen",   32'(bus.wen_o), 32'd1);
    chk("a_sel",   32'(bus.SELECT_txbl_o), 32'd1);
    chk("a_addr",  32'(bus.vram_address_o), 32'h900);
    chk("a_data",  32'(bus.data_o), 32'hC1);
    chk("a_ready", 32'(bus.char_ready_o), 32'd0);
    chk("a_busy",  32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("a_wen_end",   32'(bus.wen_o), 32'd0);
    chk("a_ready_end", 32'(bus.char_ready_o), 32'd1);
    chk("a_row", 32'(row), 32'd0);
    chk("a_col", 32'(col), 32'd1);
    chk("a_wr",  32'(wr_cnt), 32'd1);
    chk("a_mem", 32'(mem[0]), 32'hC1);

    // Walk to (29,31), then 'Z' wraps the cursor to (0,0)
    repeat (29) send(8'h0A, 1'b0);
    chk("lf29_row", 32'(row), 32'd29);
    chk("lf29_col", 32'(col), 32'd0);
    repeat (31) send(8'h61, 1'b0);
    chk("end_row", 32'(row), 32'd29);
    chk("end_col", 32'(col), 32'd31);
    cnt0 = wr_cnt;
    bus.char_i = 8'h5A; bus.color_i = 1'b0; bus.char_valid_i = 1'b1;
    tick();
    bus.char_valid_i = 1'b0;
    @(negedge clk);
    chk("z_addr", 32'(bus.vram_address_o), 32'hCBF);
    chk("z_data", 32'(bus.data_o), 32'h5A);
    tick();
    chk("z_row", 32'(row), 32'd0);
    chk("z_col", 32'(col), 32'd0);
    chk("z_wr",  32'(wr_cnt - cnt0), 32'd1);
    send(8'h0A, 1'b0);
    @(negedge clk);
    chk("lf_wen", 32'(bus.wen_o), 32'd0);
    chk("lf_row", 32'(row), 32'd1);
    chk("lf_col", 32'(col), 32'd0);
    chk("lf_wr",  32'(wr_cnt - cnt0), 32'd1);

    // Backspace across a row boundary and at the origin
    send(8'h08, 1'b0);
    chk("bs_row", 32'(row), 32'd0);
    chk("bs_col", 32'(col), 32'd31);
    send(8'h0D, 1'b0);
    chk("cr_col", 32'(col), 32'd0);
    send(8'h08, 1'b0);
    chk("bs0_row", 32'(row), 32'd0);
    chk("bs0_col", 32'(col), 32'd0);

    // Back-to-back ignored bytes with an LF in the burst: one byte per cycle
    cnt0 = wr_cnt;
    bus.char_valid_i = 1'b1;
    bus.char_i = 8'h7F; tick();
    bus.char_i = 8'h0A; tick();
    bus.char_i = 8'h80; tick();
    bus.char_i = 8'h01; tick();
    bus.char_valid_i = 1'b0;
    chk("ign_wr",    32'(wr_cnt - cnt0), 32'd0);
    chk("ign_busy",  32'(busy), 32'd0);
    chk("ign_row",   32'(row), 32'd1);
    chk("ign_col",   32'(col), 32'd0);
    chk("ign_ready", 32'(bus.char_ready_o), 32'd1);

    // Form feed with grant toggling every cycle
    cnt0 = wr_cnt;
    bus.gnt_i = 1'b0;
    bus.char_i = 8'h0C; bus.char_valid_i = 1'b1;
    tick();
    bus.char_valid_i = 1'b0;
    k = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        if (bus.wen_o !== 1'b1 || bus.SELECT_txbl_o !== 1'b1) bad++;
        if (bus.gnt_i) begin
          if (int'(bus.vram_address_o) != 'h900 + k || bus.data_o !== 8'h00) bad++;
          k++;
        end
        tick();
        bus.gnt_i = ~bus.gnt_i;
      end
    end
    chk("ff_done",  32'(done), 32'd1);
    chk("ff_count", 32'(k), 32'd960);
    chk("ff_bad",   32'(bad), 32'd0);
    chk("ff_wr",    32'(wr_cnt - cnt0), 32'd960);
    chk("ff_row",   32'(row), 32'd0);
    chk("ff_col",   32'(col), 32'd0);
    chk("ff_ready", 32'(bus.char_ready_o), 32'd1);
    chk("ff_wen",   32'(bus.wen_o), 32'd0);

    // 'B' with grant withheld for 5 cycles
    tick();
    chk("ff_mem_last", 32'(mem[959]), 32'd0);
    bus.gnt_i = 1'b0;
    cnt0 = wr_cnt;
    bus.char_i = 8'h42; bus.color_i = 1'b0; bus.char_valid_i = 1'b1;
    tick();
    bus.char_valid_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wen_o !== 1'b1 || bus.vram_address_o !== 12'h900 ||
          bus.data_o !== 8'h42 || bus.char_ready_o !== 1'b0) bad++;
      tick();
      if (i == 4) bus.gnt_i = 1'b1;
    end
    @(negedge clk);
    chk("b_stable", 32'(bad), 32'd0);
    chk("b_wen",    32'(bus.wen_o), 32'd0);
    chk("b_ready",  32'(bus.char_ready_o), 32'd1);
    chk("b_wr",     32'(wr_cnt - cnt0), 32'd1);
    chk("b_col",    32'(col), 32'd1);
    chk("b_mem",    32'(mem[0]), 32'h42);

    // Put a marker at entry 128, then reset 100 writes into a clear
    repeat (4) send(8'h0A, 1'b0);
    send(8'h51, 1'b1);
    chk("q_mem", 32'(mem[128]), 32'hD1);
    cnt0 = wr_cnt;
    bus.char_i = 8'h0C; bus.char_valid_i = 1'b1;
    tick();
    bus.char_valid_i = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    bus.gnt_i = 1'b0;
    @(negedge clk);
    chk("rc_addr", 32'(bus.vram_address_o), 32'h964);
    chk("rc_wr",   32'(wr_cnt - cnt0), 32'd100);
    tick();
    @(negedge clk);
    chk("rc_wen",   32'(bus.wen_o), 32'd0);
    chk("rc_busy",  32'(busy), 32'd0);
    chk("rc_ready", 32'(bus.char_ready_o), 32'd0);
    chk("rc_row",   32'(row), 32'd0);
    chk("rc_col",   32'(col), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rc_ready_after", 32'(bus.char_ready_o), 32'd1);
    chk("rc_keep",        32'(mem[128]), 32'hD1);
    chk("rc_cleared",     32'(mem[0]), 32'h00);

    // Normal operation resumes after the abort
    bus.gnt_i = 1'b1;
    send(8'h43, 1'b0);
    chk("post_mem", 32'(mem[0]), 32'h43);
    chk("post_col", 32'(col), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
